// File: rtl/protocol_engine_def.sv
// protocol_engine_def
// Shared definitions for the protocol engine blocks: head field layout,
// head width, producer-manager FSM encodings and default build sizes.
// No ports (package).
package protocol_engine_def;

  // 64-bit request/response head layout
  localparam int HEAD_W    = 64;
  localparam int CQN_LSB   = 0;
  localparam int CQN_FW    = 24;
  localparam int LEN_LSB   = 32;
  localparam int LEN_FW    = 32;
  localparam int OFF_LSB   = 32;
  localparam int OFF_FW    = 24;
  localparam int PHASE_BIT = 56;

  // Default build sizes
  localparam int CQ_NUM_LOG_DEF = 8;
  localparam int CQE_LENGTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_CLR   = 2'd2
  } cq_state_e;

endpackage

// File: rtl/SRAM_SDP_Template.sv
// SRAM_SDP_Template
// Simple dual-port RAM: one write port, one read port with a registered
// read (1-cycle latency). A read of an address written in the same cycle
// returns the old contents. Contents are not reset.
// Ports:
//   clk         clock
//   wr_en_i     write enable
//   wr_addr_i   write address
//   wr_data_i   write data
//   rd_en_i     read enable; rd_data_o holds its value when low
//   rd_addr_i   read address
//   rd_data_o   registered read data
module SRAM_SDP_Template #(
  parameter int DW = 25,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n
// Round-robin arbiter over N requesters with a one-hot grant. The search
// starts at the channel after the last accepted grant; the pointer only
// moves when the grant is accepted.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   req_i      per-requester request
//   accept_i   current grant is taken this cycle
//   grant_o    one-hot grant (combinational)
module rr_arbiter_n #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q, last_d;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx_v;
  logic          found;

  always_comb begin
    grant_o = '0;
    win_idx = last_q;
    idx_v   = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx_v = PW'((int'(last_q) + k) % N);
      if (!found && req_i[idx_v]) begin
        grant_o[idx_v] = 1'b1;
        win_idx        = idx_v;
        found          = 1'b1;
      end
    end
    last_d = (accept_i && found) ? win_idx : last_q;
  end

  // Pointer resets to the last channel so channel 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= PW'(N - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/cq_producer_mgt.sv
// cq_producer_mgt
// Per-CQ producer pointer manager. Channels request a CQE slot on a CQ;
// the block returns the current {phase, offset} of that CQ and advances
// the stored offset by CQE_LENGTH, wrapping to 0 and toggling the phase
// at the CQ length. A clear port zeroes one table entry.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cq_req_valid    per-channel request valid
//   cq_req_head     per-channel head: [23:0] CQN, [63:32] CQ length (bytes)
//   cq_req_ready    per-channel request accept
//   cq_resp_valid   per-channel response valid
//   cq_resp_head    per-channel response: [23:0] CQN, [55:32] offset, [56] phase
//   cq_resp_ready   per-channel response accept
//   cq_clr_valid    clear request
//   cq_clr_cqn      CQN to clear
//   cq_clr_ready    clear accept (one cycle, in CLR)
module cq_producer_mgt
  import protocol_engine_def::*;
#(
  parameter int CHNL_NUM     = 3,
  parameter int CQ_NUM_LOG   = CQ_NUM_LOG_DEF,
  parameter int OFFSET_WIDTH = 24,
  parameter int CQE_LENGTH   = CQE_LENGTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHNL_NUM-1:0]        cq_req_valid,
  input  logic [CHNL_NUM*HEAD_W-1:0] cq_req_head,
  output logic [CHNL_NUM-1:0]        cq_req_ready,
  output logic [CHNL_NUM-1:0]        cq_resp_valid,
  output logic [CHNL_NUM*HEAD_W-1:0] cq_resp_head,
  input  logic [CHNL_NUM-1:0]        cq_resp_ready,
  input  logic                       cq_clr_valid,
  input  logic [CQ_NUM_LOG-1:0]      cq_clr_cqn,
  output logic                       cq_clr_ready
);

  localparam int EW    = OFFSET_WIDTH + 1;
  localparam int CMP_W = (EW > LEN_FW) ? EW : LEN_FW;

  cq_state_e             state_q, state_d;
  logic [CHNL_NUM-1:0]   gnt_q, gnt_d;
  logic [CQ_NUM_LOG-1:0] cqn_q, cqn_d;
  logic [LEN_FW-1:0]     len_q, len_d;
  logic                  byp_vld_q, byp_vld_d;
  logic [EW-1:0]         byp_data_q, byp_data_d;

  logic [CHNL_NUM-1:0]   arb_req, arb_gnt;
  logic                  arb_take;
  logic [HEAD_W-1:0]     sel_head;
  logic [CQ_NUM_LOG-1:0] sel_cqn;
  logic [LEN_FW-1:0]     sel_len;

  logic                  wr_en;
  logic [CQ_NUM_LOG-1:0] wr_addr;
  logic [EW-1:0]         wr_data;
  logic [EW-1:0]         rd_data;

  logic                  serving, serve_done;
  logic [EW-1:0]         cur_entry, upd_entry, next_sum;
  logic                  cur_phase, wrap;
  logic [OFFSET_WIDTH-1:0] cur_off;
  logic [HEAD_W-1:0]     resp_word;
  logic                  unused_head_bits;

  assign serving    = (state_q == ST_SERVE);
  assign serve_done = serving && |(gnt_q & cq_resp_ready);

  // The channel being served has its request consumed this cycle, so it
  // must not be re-granted on the same valid during a back-to-back handoff.
  assign arb_req = cq_req_valid & ~(serving ? gnt_q : '0);

  rr_arbiter_n #(.N(CHNL_NUM)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (arb_req),
    .accept_i (arb_take),
    .grant_o  (arb_gnt)
  );

  always_comb begin
    sel_head = '0;
    for (int i = 0; i < CHNL_NUM; i++) begin
      if (arb_gnt[i]) sel_head = sel_head | cq_req_head[i*HEAD_W +: HEAD_W];
    end
  end

  assign sel_cqn          = sel_head[CQ_NUM_LOG-1:0];
  assign sel_len          = sel_head[LEN_LSB +: LEN_FW];
  assign unused_head_bits = ^sel_head[LEN_LSB-1:CQ_NUM_LOG];

  // The SRAM read is one cycle stale when the previous SERVE wrote the same
  // CQN in the cycle of the read; the bypass register covers that case.
  assign cur_entry = byp_vld_q ? byp_data_q : rd_data;
  assign cur_phase = cur_entry[OFFSET_WIDTH];
  assign cur_off   = cur_entry[OFFSET_WIDTH-1:0];
  assign next_sum  = {1'b0, cur_off} + EW'(CQE_LENGTH);
  assign wrap      = CMP_W'(next_sum) >= CMP_W'(len_q);
  assign upd_entry = wrap ? {~cur_phase, {OFFSET_WIDTH{1'b0}}}
                          : {cur_phase, next_sum[OFFSET_WIDTH-1:0]};

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cqn_d      = cqn_q;
    len_d      = len_q;
    byp_vld_d  = byp_vld_q;
    byp_data_d = byp_data_q;
    wr_en      = 1'b0;
    wr_addr    = cqn_q;
    wr_data    = upd_entry;
    arb_take   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cq_clr_valid) begin
          state_d = ST_CLR;
        end else if (|arb_gnt) begin
          arb_take  = 1'b1;
          state_d   = ST_SERVE;
          gnt_d     = arb_gnt;
          cqn_d     = sel_cqn;
          len_d     = sel_len;
          byp_vld_d = 1'b0;
        end
      end
      ST_SERVE: begin
        if (serve_done) begin
          wr_en = 1'b1;
          if (cq_clr_valid) begin
            state_d   = ST_CLR;
            gnt_d     = '0;
            byp_vld_d = 1'b0;
          end else if (|arb_gnt) begin
            arb_take   = 1'b1;
            gnt_d      = arb_gnt;
            cqn_d      = sel_cqn;
            len_d      = sel_len;
            byp_vld_d  = (sel_cqn == cqn_q);
            byp_data_d = upd_entry;
          end else begin
            state_d   = ST_IDLE;
            gnt_d     = '0;
            byp_vld_d = 1'b0;
          end
        end
      end
      ST_CLR: begin
        wr_en   = 1'b1;
        wr_addr = cq_clr_cqn;
        wr_data = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      cqn_q      <= '0;
      len_q      <= '0;
      byp_vld_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cqn_q      <= cqn_d;
      len_q      <= len_d;
      byp_vld_q  <= byp_vld_d;
      byp_data_q <= byp_data_d;
    end
  end

  SRAM_SDP_Template #(.DW(EW), .AW(CQ_NUM_LOG)) u_tbl (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (arb_take),
    .rd_addr_i (sel_cqn),
    .rd_data_o (rd_data)
  );

  always_comb begin
    resp_word = '0;
    resp_word[CQN_LSB +: CQN_FW] = CQN_FW'(cqn_q);
    resp_word[OFF_LSB +: OFF_FW] = OFF_FW'(cur_off);
    resp_word[PHASE_BIT]         = cur_phase;
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHNL_NUM; gi++) begin : g_chnl
      assign cq_req_ready[gi]                    = serving & gnt_q[gi];
      assign cq_resp_valid[gi]                   = serving & gnt_q[gi];
      assign cq_resp_head[gi*HEAD_W +: HEAD_W]   = (serving & gnt_q[gi]) ? resp_word : '0;
    end
  endgenerate

  assign cq_clr_ready = (state_q == ST_CLR);

endmodule

// File: tb/tb_cq_producer_mgt.sv
// Testbench for cq_producer_mgt: table-driven allocation vectors plus
// hand-written sequences for round-robin, bypass, stall, clear priority
// and reset mid-SERVE.
module tb_cq_producer_mgt;

  localparam int CH  = 3;
  localparam int CQL = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CH-1:0]       cq_req_valid = '0;
  logic [CH*64-1:0]    cq_req_head = '0;
  logic [CH-1:0]       cq_req_ready;
  logic [CH-1:0]       cq_resp_valid;
  logic [CH*64-1:0]    cq_resp_head;
  logic [CH-1:0]       cq_resp_ready = '0;
  logic                cq_clr_valid = 1'b0;
  logic [CQL-1:0]      cq_clr_cqn = '0;
  logic                cq_clr_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cq_producer_mgt #(
    .CHNL_NUM(CH), .CQ_NUM_LOG(CQL), .OFFSET_WIDTH(24), .CQE_LENGTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .cq_req_valid(cq_req_valid), .cq_req_head(cq_req_head), .cq_req_ready(cq_req_ready),
    .cq_resp_valid(cq_resp_valid), .cq_resp_head(cq_resp_head), .cq_resp_ready(cq_resp_ready),
    .cq_clr_valid(cq_clr_valid), .cq_clr_cqn(cq_clr_cqn), .cq_clr_ready(cq_clr_ready)
  );

  typedef struct {
    int ch;
    int cqn;
    int len;
    int off;
    bit ph;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_req(input int cqn, input int len);
    logic [63:0] h;
    h = '0;
    h[23:0]  = cqn[23:0];
    h[63:32] = len[31:0];
    return h;
  endfunction

  function automatic logic [63:0] exp_head(input int cqn, input int off, input bit ph);
    logic [63:0] h;
    h = '0;
    h[23:0]  = cqn[23:0];
    h[55:32] = off[23:0];
    h[56]    = ph;
    return h;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic do_clear(input int cqn);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    cq_clr_valid = 1'b1;
    cq_clr_cqn   = cqn[CQL-1:0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cq_clr_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cq_clr_valid = 1'b0;
    chk($sformatf("clr%0d_ready", cqn), {63'b0, ok}, 64'd1);
    $display("clear cqn=%0d ready_seen=%0d", cqn, ok);
  endtask

  // Waits (bounded) at negedges for the response of channel ch.
  task automatic wait_resp(input int ch, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cq_resp_valid[ch]) begin ok = 1'b1; break; end
    end
    chk({name, "_seen"}, {63'b0, ok}, 64'd1);
  endtask

  task automatic do_req(input int ch, input int cqn, input int len, input string name,
                        output logic [63:0] head, output logic [CH-1:0] rv);
    @(negedge clk);
    cq_req_head[ch*64 +: 64] = mk_req(cqn, len);
    cq_req_valid[ch] = 1'b1;
    cq_resp_ready    = '1;
    wait_resp(ch, name);
    head = cq_resp_head[ch*64 +: 64];
    rv   = cq_resp_valid;
    cq_req_valid[ch] = 1'b0;
  endtask

  initial begin
    logic [63:0]   head;
    logic [CH-1:0] rv;
    logic [CH-1:0] exp_oh;

    // ---- reset state ----
    @(negedge clk);
    chk("rst_resp_valid", 64'(cq_resp_valid), 64'd0);
    chk("rst_req_ready",  64'(cq_req_ready),  64'd0);
    chk("rst_clr_ready",  64'(cq_clr_ready),  64'd0);
    chk("rst_resp_head",  cq_resp_head[63:0] | cq_resp_head[127:64] | cq_resp_head[191:128], 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven allocations ----
    for (int i = 0; i < 9; i++)
      vt[i] = '{ch: 0, cqn: 5, len: 'h100, off: (i < 8) ? i * 'h20 : 0, ph: (i == 8)};
    vt[9]  = '{ch: 1, cqn: 7, len: 'h40, off: 'h00, ph: 1'b0};
    vt[10] = '{ch: 1, cqn: 7, len: 'h40, off: 'h20, ph: 1'b0};
    vt[11] = '{ch: 1, cqn: 7, len: 'h40, off: 'h00, ph: 1'b1};
    vt[12] = '{ch: 1, cqn: 7, len: 'h40, off: 'h20, ph: 1'b1};
    vt[13] = '{ch: 2, cqn: 9, len: 'h10, off: 'h00, ph: 1'b0};
    vt[14] = '{ch: 2, cqn: 9, len: 'h10, off: 'h00, ph: 1'b1};
    vt[15] = '{ch: 2, cqn: 9, len: 'h10, off: 'h00, ph: 1'b0};
    vt[16] = '{ch: 0, cqn: 5, len: 'h100, off: 'h20, ph: 1'b1};

    do_clear(5);
    do_clear(7);
    do_clear(9);
    for (int i = 0; i < 17; i++) begin
      do_req(vt[i].ch, vt[i].cqn, vt[i].len, $sformatf("vec%0d", i), head, rv);
      exp_oh = '0;
      exp_oh[vt[i].ch] = 1'b1;
      chk($sformatf("vec%0d_head", i), head, exp_head(vt[i].cqn, vt[i].off, vt[i].ph));
      chk($sformatf("vec%0d_valid", i), 64'(rv), 64'(exp_oh));
      $display("vec%0d ch=%0d cqn=%0d off=0x%0h ph=%0d", i, vt[i].ch, vt[i].cqn, head[55:32], head[56]);
    end

    // ---- round-robin, all channels valid continuously ----
    do_reset();
    do_clear(1);
    do_clear(2);
    do_clear(3);
    @(negedge clk);
    for (int c = 0; c < CH; c++) cq_req_head[c*64 +: 64] = mk_req(c + 1, 'h100);
    cq_resp_ready = '1;
    cq_req_valid  = '1;
    wait_resp(0, "rr_first");
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      exp_oh = '0;
      exp_oh[k % 3] = 1'b1;
      chk($sformatf("rr%0d_grant", k), 64'(cq_resp_valid), 64'(exp_oh));
      chk($sformatf("rr%0d_ready", k), 64'(cq_req_ready), 64'(exp_oh));
      chk($sformatf("rr%0d_head", k), cq_resp_head[(k % 3)*64 +: 64],
          exp_head((k % 3) + 1, (k / 3) * 'h20, 1'b0));
      $display("rr cycle %0d resp_valid=%b", k, cq_resp_valid);
    end
    cq_req_valid = '0;

    // ---- back-to-back same CQN (bypass) ----
    do_reset();
    do_clear(20);
    @(negedge clk);
    cq_req_head[0 +: 64]  = mk_req(20, 'h100);
    cq_req_head[64 +: 64] = mk_req(20, 'h100);
    cq_resp_ready = '1;
    cq_req_valid  = 3'b011;
    wait_resp(0, "byp_a");
    chk("byp_a_head", cq_resp_head[0 +: 64], exp_head(20, 'h00, 1'b0));
    cq_req_valid[0] = 1'b0;
    @(negedge clk);
    chk("byp_b_valid", 64'(cq_resp_valid), 64'd2);
    chk("byp_b_head", cq_resp_head[64 +: 64], exp_head(20, 'h20, 1'b0));
    $display("bypass second resp off=0x%0h", cq_resp_head[64+32 +: 24]);
    cq_req_valid[1] = 1'b0;
    do_req(2, 20, 'h100, "byp_c", head, rv);
    chk("byp_c_head", head, exp_head(20, 'h40, 1'b0));

    // ---- response stall ----
    do_clear(30);
    @(negedge clk);
    cq_req_head[0 +: 64] = mk_req(30, 'h100);
    cq_resp_ready = '0;
    cq_req_valid[0] = 1'b1;
    wait_resp(0, "stall");
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      chk($sformatf("stall%0d_head", s), cq_resp_head[0 +: 64], exp_head(30, 0, 1'b0));
      chk($sformatf("stall%0d_valid", s), 64'(cq_resp_valid), 64'd1);
    end
    cq_resp_ready   = '1;
    cq_req_valid[0] = 1'b0;
    do_req(0, 30, 'h100, "stall_next", head, rv);
    chk("stall_next_head", head, exp_head(30, 'h20, 1'b0));
    $display("stall next off=0x%0h", head[55:32]);

    // ---- clear with a request pending ----
    do_clear(40);
    do_req(0, 40, 'h100, "cp_a", head, rv);
    chk("cp_a_head", head, exp_head(40, 'h00, 1'b0));
    do_req(0, 40, 'h100, "cp_b", head, rv);
    chk("cp_b_head", head, exp_head(40, 'h20, 1'b0));
    @(negedge clk);
    cq_req_head[0 +: 64] = mk_req(40, 'h100);
    cq_req_valid[0] = 1'b1;
    cq_clr_valid    = 1'b1;
    cq_clr_cqn      = 8'd40;
    @(negedge clk);
    chk("cp_clr_first", 64'(cq_clr_ready), 64'd1);
    chk("cp_no_resp", 64'(cq_resp_valid), 64'd0);
    @(posedge clk); #1;
    cq_clr_valid = 1'b0;
    wait_resp(0, "cp_after");
    chk("cp_after_head", cq_resp_head[0 +: 64], exp_head(40, 'h00, 1'b0));
    $display("clear-priority next off=0x%0h ph=%0d", cq_resp_head[55:32], cq_resp_head[56]);
    cq_req_valid[0] = 1'b0;

    // ---- reset mid-SERVE ----
    do_clear(50);
    @(negedge clk);
    cq_req_head[0 +: 64] = mk_req(50, 'h100);
    cq_resp_ready   = '0;
    cq_req_valid[0] = 1'b1;
    wait_resp(0, "rs");
    rst = 1'b1;
    #1;
    chk("rs_resp_dropped", 64'(cq_resp_valid), 64'd0);
    chk("rs_ready_dropped", 64'(cq_req_ready), 64'd0);
    cq_req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_req(0, 50, 'h100, "rs_next", head, rv);
    chk("rs_next_head", head, exp_head(50, 'h00, 1'b0));
    $display("reset-mid-serve next off=0x%0h", head[55:32]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cq_producer_mgt.md
CQ_PRODUCER_MGT -- requirements
Module: cq_producer_mgt

Interface
REQ-001 Parameter CHNL_NUM, default 3: number of requesting channels (TX_REQ=0, RX_REQ=1, RX_RESP=2 in the default build).
REQ-002 Parameter CQ_NUM_LOG, default `CQ_NUM_LOG: CQN index width; table depth is 2^CQ_NUM_LOG.
REQ-003 Parameter OFFSET_WIDTH, default 24: producer byte-offset width.
REQ-004 Parameter CQE_LENGTH, default `CQE_LENGTH: offset increment per allocation, in bytes.
REQ-005 Ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-006 cq_req_valid  in  CHNL_NUM  per-channel request valid.
REQ-007 cq_req_head  in  CHNL_NUM*64  per-channel head; bits [23:0] carry the CQN and [63:32] carry the CQ length in bytes; channel i occupies slice [64i+63:64i].
REQ-008 cq_req_ready  out  CHNL_NUM  per-channel request accept.
REQ-009 cq_resp_valid  out  CHNL_NUM  per-channel response valid.
REQ-010 cq_resp_head  out  CHNL_NUM*64  per-channel response: [23:0] CQN, [31:24] zero, [55:32] offset, [56] phase, [63:57] zero.
REQ-011 cq_resp_ready  in  CHNL_NUM  per-channel response accept.
REQ-012 cq_clr_valid  in  1, cq_clr_cqn  in  CQ_NUM_LOG, cq_clr_ready  out  1: clear one CQ entry at CQ create/destroy.

Function
REQ-013 Table entry = {phase, offset}, OFFSET_WIDTH+1 bits, held in a 1-read/1-write SDP SRAM with 1-cycle read latency.
REQ-014 FSM states: IDLE, SERVE, CLR.
REQ-015 IDLE: if cq_clr_valid is high, go to CLR; otherwise, if any cq_req_valid is high, grant one channel round-robin starting after the last served channel, latch the CQN and length, drive the read address combinationally, and go to SERVE.
REQ-016 CLR: hold cq_clr_ready=1 for one cycle, write {0,0} to cq_clr_cqn, and return to IDLE.
REQ-017 SERVE: for the granted channel g, cq_req_ready[g]=cq_resp_valid[g]=1 and cq_resp_head[g] = current {phase, offset}; all other channels hold 0 on these outputs.
REQ-018 SERVE with cq_resp_ready[g]=1: write the updated entry. next = offset+CQE_LENGTH, computed at OFFSET_WIDTH+1 bits. If next >= length, the offset becomes 0 and the phase toggles; otherwise the offset becomes next and the phase is unchanged.
REQ-019 SERVE with cq_resp_ready[g]=0: hold every output stable and perform no write.
REQ-020 Back-to-back: on SERVE completion with no cq_clr_valid and another request pending, arbitrate in that cycle and go directly to SERVE. Sustained throughput is one allocation per cycle while resp_ready is high.
REQ-021 Bypass: if the newly granted CQN equals the CQN being written in the same cycle, the next SERVE uses the written value, not the SRAM output.
REQ-022 On SERVE completion with cq_clr_valid high, go to CLR; clear has priority over requests.
REQ-023 If a clear arrives for a CQN that is in SERVE, the clear applies after the SERVE write completes.
REQ-024 Length below CQE_LENGTH: every allocation returns offset 0 and toggles the phase.
REQ-025 Allocation latency: response valid 1 cycle after grant.
REQ-026 A channel that deasserts cq_req_valid without being granted is simply skipped.

Reset
REQ-027 rst asynchronously forces: state IDLE, round-robin pointer so that channel 0 has highest priority first, latched CQN/length 0, bypass register invalid, and all outputs 0.
REQ-028 Table contents are not reset; software clears each CQ via the clear port before use.
REQ-029 Reset asserted mid-SERVE drops the transaction with no write, and the response is never seen.

Structure
REQ-030 The head field offsets, the 64-bit head widths and the state encodings live in the shared protocol_engine_def package.
REQ-031 A single sub-module, rr_arbiter_n (parametrised CHNL_NUM, one-hot grant, pointer advance on accept), is instantiated alongside SRAM_SDP_Template.

Verification
REQ-032 Clear CQN 5, then send 3 TX requests (length 0x100, CQE_LENGTH 0x20) -> responses carry offsets 0x00, 0x20, 0x40 with phase 0.
REQ-033 Wrap: 8 requests on CQN 5 with length 0x100 -> the 8th returns offset 0xE0; the 9th returns offset 0x00 with phase 1.
REQ-034 All 3 channels valid continuously on distinct CQNs -> grants follow the order 0,1,2,0,1,2 with one response per cycle.
REQ-035 Channels 0 and 1 hit the same CQN back-to-back -> offsets 0x00 then 0x20 (bypass exercised), with no duplicate.
REQ-036 cq_resp_ready held low for 4 cycles -> the head stays stable and the next allocation shows no advance.
REQ-037 Clear asserted while requests are pending -> the clear is serviced first, and the next allocation on that CQN returns offset 0 with phase 0.
